// File: rtl/sar_search_4bit.sv
// rtl/sar_search_4bit.sv - successive-approximation search over an external comparator
// Optional SAR_EARLY_EXIT_EN: finish on the first equal comparison.
module sar_search_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       r,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] TOP_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        FIN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] next_acc;
    logic             decision_ok;
    logic             last_step;

    assign bit_mask = WIDTH'(1) << idx;
    assign guess    = (state == SEARCH) ? (acc | bit_mask) : '0;
    assign busy     = (state == SEARCH);
    assign done     = (state == FIN);

    // Decode this cycle's comparator answer into the next accumulator value.
    always_comb begin
        next_acc    = acc;
        decision_ok = 1'b1;
        last_step   = (idx == '0);
        case (r)
            3'b100: next_acc = acc | bit_mask;
            3'b001: next_acc = acc & ~bit_mask;
            3'b010: begin
                next_acc = acc | bit_mask;
`ifdef SAR_EARLY_EXIT_EN
                last_step = 1'b1;
`endif
            end
            default: decision_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            idx    <= TOP_IDX;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        idx   <= TOP_IDX;
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (!decision_ok) begin
                        // Malformed comparator code: abort with a cleared result.
                        err    <= 1'b1;
                        result <= '0;
                        state  <= FIN;
                    end else begin
                        acc <= next_acc;
                        if (last_step) begin
                            result <= next_acc;
                            err    <= 1'b0;
                            state  <= FIN;
                        end else begin
                            idx <= idx - IW'(1);
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sar_search_4bit.sv
// tb/tb_sar_search_4bit.sv - directed bench for sar_search_4bit with a behavioural comparator
module tb_sar_search_4bit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] r;
    logic [3:0] guess;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       err;

    sar_search_4bit #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .r(r),
        .guess(guess), .busy(busy), .done(done), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    logic [3:0] a_val = 4'd0;
    logic       force_now = 1'b0;
    logic [2:0] force_code = 3'b000;

    // Comparator with A = a_val, B = guess, plus an override for fault injection.
    always_comb begin
        if (force_now)            r = force_code;
        else if (a_val > guess)   r = 3'b100;
        else if (a_val == guess)  r = 3'b010;
        else                      r = 3'b001;
    end

    int checks = 0;
    int failures = 0;

    logic [3:0] obs_guess [0:7];
    int         obs_n;
    int         obs_done_edge;
    int         obs_done_cnt;
    int         err_at = 0;
    logic       pulse_busy = 1'b0;
    logic [15:0] gseq;

    task automatic do_search(input logic [3:0] a);
        a_val = a;
        obs_n = 0;
        obs_done_edge = 0;
        obs_done_cnt = 0;
        force_now = 1'b0;
        for (int i = 0; i < 8; i++) obs_guess[i] = 4'hx;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 12 && obs_done_cnt == 0; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            force_now = 1'b0;
            if (busy) begin
                if (obs_n < 8) obs_guess[obs_n] = guess;
                obs_n++;
                force_now = (obs_n == err_at);
                if (pulse_busy) start = (obs_n % 2 == 1);
            end
            if (done) begin
                obs_done_cnt++;
                obs_done_edge = n + 1;
                start = 1'b0;
            end
        end
        force_now = 1'b0;
        gseq = {obs_guess[0], obs_guess[1], obs_guess[2], obs_guess[3]};
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({guess, busy, done, result, err} !== 11'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=%b", {guess, busy, done, result, err}, 11'b0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        do_search(4'd9);
        checks++;
        if (gseq !== {4'd8, 4'd12, 4'd10, 4'd9}) begin
            failures++; $display("FAIL a9_guess_seq got=%h want=%h", gseq, {4'd8, 4'd12, 4'd10, 4'd9});
        end
        checks++;
        if (obs_n !== 4) begin failures++; $display("FAIL a9_busy_cycles got=%0d want=4", obs_n); end
        checks++;
        if (obs_done_edge !== 6) begin failures++; $display("FAIL a9_done_edge got=%0d want=6", obs_done_edge); end
        checks++;
        if ({result, err} !== {4'd9, 1'b0}) begin
            failures++; $display("FAIL a9_result got=%0d err=%b want=9 err=0", result, err);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin failures++; $display("FAIL a9_done_pulse got done/busy=%b want=00", {done, busy}); end
    endtask

    task automatic test_extremes;
        do_search(4'd0);
        checks++;
        if (gseq !== {4'd8, 4'd4, 4'd2, 4'd1}) begin
            failures++; $display("FAIL a0_guess_seq got=%h want=%h", gseq, {4'd8, 4'd4, 4'd2, 4'd1});
        end
        checks++;
        if ({result, err, obs_done_cnt[1:0]} !== {4'd0, 1'b0, 2'd1}) begin
            failures++; $display("FAIL a0_result got=%0d err=%b dones=%0d want=0 0 1", result, err, obs_done_cnt);
        end
        do_search(4'd15);
        checks++;
        if (gseq !== {4'd8, 4'd12, 4'd14, 4'd15}) begin
            failures++; $display("FAIL a15_guess_seq got=%h want=%h", gseq, {4'd8, 4'd12, 4'd14, 4'd15});
        end
        checks++;
        if ({result, err} !== {4'd15, 1'b0}) begin
            failures++; $display("FAIL a15_result got=%0d err=%b want=15 0", result, err);
        end
    endtask

    task automatic test_equal_early;
        do_search(4'd8);
        checks++;
        if ({result, err} !== {4'd8, 1'b0}) begin
            failures++; $display("FAIL a8_result got=%0d err=%b want=8 0", result, err);
        end
`ifdef SAR_EARLY_EXIT_EN
        checks++;
        if (obs_n !== 1 || obs_done_edge !== 3) begin
            failures++; $display("FAIL a8_latency got busy=%0d edge=%0d want busy=1 edge=3", obs_n, obs_done_edge);
        end
`else
        checks++;
        if (gseq !== {4'd8, 4'd12, 4'd10, 4'd9}) begin
            failures++; $display("FAIL a8_guess_seq got=%h want=%h", gseq, {4'd8, 4'd12, 4'd10, 4'd9});
        end
        checks++;
        if (obs_n !== 4 || obs_done_edge !== 6) begin
            failures++; $display("FAIL a8_latency got busy=%0d edge=%0d want busy=4 edge=6", obs_n, obs_done_edge);
        end
`endif
    endtask

    task automatic test_error;
        err_at = 2;
        force_code = 3'b000;
        do_search(4'd9);
        err_at = 0;
        checks++;
        if ({result, err} !== {4'd0, 1'b1}) begin
            failures++; $display("FAIL abort_result got=%0d err=%b want=0 1", result, err);
        end
        checks++;
        if (obs_n !== 2 || obs_done_edge !== 4) begin
            failures++; $display("FAIL abort_timing got busy=%0d edge=%0d want busy=2 edge=4", obs_n, obs_done_edge);
        end
        do_search(4'd5);
        checks++;
        if ({result, err} !== {4'd5, 1'b0}) begin
            failures++; $display("FAIL after_abort got=%0d err=%b want=5 0", result, err);
        end
    endtask

    task automatic test_reset_mid;
        int dones;
        logic was_busy;
        a_val = 4'd9;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        was_busy = busy;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({was_busy, guess, busy, done, result, err} !== {1'b1, 11'b0}) begin
            failures++; $display("FAIL mid_reset got=%b want=%b", {was_busy, guess, busy, done, result, err}, {1'b1, 11'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        checks++;
        if (dones !== 0) begin failures++; $display("FAIL no_done_after_reset got=%0d want=0", dones); end
        do_search(4'd6);
        checks++;
        if ({result, err, obs_done_cnt[1:0]} !== {4'd6, 1'b0, 2'd1}) begin
            failures++; $display("FAIL a6_after_reset got=%0d err=%b dones=%0d want=6 0 1", result, err, obs_done_cnt);
        end
    endtask

    task automatic test_back_to_back;
        int dones;
        int bad_results;
        int last_n;
        int bad_gap;
        a_val = 4'd3;
        dones = 0; bad_results = 0; last_n = 0; bad_gap = 0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (result !== 4'd3 || err !== 1'b0) bad_results++;
                if (last_n != 0 && n - last_n != 6) bad_gap++;
                last_n = n;
            end
        end
        start = 1'b0;
        checks++;
        if (dones !== 3) begin failures++; $display("FAIL b2b_done_count got=%0d want=3", dones); end
        checks++;
        if (bad_results !== 0 || bad_gap !== 0) begin
            failures++; $display("FAIL b2b_results got bad_results=%0d bad_gaps=%0d want 0 0", bad_results, bad_gap);
        end
        repeat (8) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin failures++; $display("FAIL b2b_stop got=%b want=00", {busy, done}); end
    endtask

    task automatic test_start_during_busy;
        int extra;
        pulse_busy = 1'b1;
        do_search(4'd9);
        pulse_busy = 1'b0;
        checks++;
        if (gseq !== {4'd8, 4'd12, 4'd10, 4'd9} || obs_done_edge !== 6) begin
            failures++; $display("FAIL busy_start_seq got=%h edge=%0d want=%h edge=6", gseq, obs_done_edge, {4'd8, 4'd12, 4'd10, 4'd9});
        end
        checks++;
        if ({result, err} !== {4'd9, 1'b0}) begin
            failures++; $display("FAIL busy_start_result got=%0d err=%b want=9 0", result, err);
        end
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        checks++;
        if (extra !== 0) begin failures++; $display("FAIL busy_start_queued got=%0d want=0", extra); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_equal_early();
        test_error();
        test_reset_mid();
        test_back_to_back();
        test_start_during_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sar_search_4bit.md
# sar_search_4bit

Successive-approximation search engine: the consumer side of the team's combinational magnitude comparator. It recovers an unknown value that is wired to comparator input A. It does this by driving trial values onto comparator input B and reading back the 3-bit result R, one bit decision per clock. It sits beside the comparator in the Unit 4 datapath exercises and produces a registered result with a done pulse.

## Interface
- WIDTH, 4, operand width in bits; sets the search length and the width of GUESS and RESULT.

- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  request a search; sampled only in IDLE.
- R  input  3  comparator result, one-hot: R[2]=A>B, R[1]=A==B, R[0]=A<B; combinational from GUESS.
- GUESS  output  WIDTH  trial value driven to comparator B.
- BUSY  output  1  high while in SEARCH.
- DONE  output  1  one-cycle pulse when RESULT/ERR are valid.
- RESULT  output  WIDTH  recovered value; holds until the next DONE.
- ERR  output  1  last search aborted on a non-one-hot R; holds until the next DONE.

## Operation
- States:
  - IDLE
  - SEARCH
  - FIN
- Registers:
  - acc[WIDTH-1:0]
  - idx (bit pointer, WIDTH-1 down to 0).
- IDLE:
  - GUESS=0, BUSY=0.
  - START=1 → acc←0, idx←WIDTH-1, go to SEARCH.
- SEARCH:
  - GUESS = acc | (1<<idx), combinational from registers.
  - R sampled at each rising edge:
    - R=3'b100 (unknown > guess): acc[idx]←1.
    - R=3'b001 (unknown < guess): acc[idx]←0.
    - R=3'b010 (equal): acc[idx]←1; further behaviour per Configuration.
    - Any other code: ERR←1, RESULT←0, go to FIN.
  - If idx==0 after a valid decision, go to FIN. Otherwise idx←idx-1.
- FIN:
  - RESULT←acc, unless aborted. DONE=1 for exactly this cycle.
  - ERR updated: cleared on success, set on abort.
  - Next state is IDLE.
- START is ignored while BUSY or in FIN; no queuing.
- A held START retriggers a new search on the IDLE cycle after FIN.
- Arithmetic: unsigned only; GUESS never exceeds 2^WIDTH-1.

## Timing
- Reset (asynchronous, any state): state=IDLE, acc=0, idx=WIDTH-1, GUESS=0, BUSY=0, DONE=0, RESULT=0, ERR=0.
- Reset mid-search discards the search; no DONE is produced.
- Latency, START edge to DONE high:
  - Full search: WIDTH+1 cycles (1 to enter SEARCH, WIDTH decisions, DONE in FIN).
  - With WIDTH=4: DONE on the 6th rising edge after START is sampled, counting the START edge as edge 1.
- BUSY is high for exactly the number of decision cycles.
- The comparator path from GUESS to R must settle within one CLK period. R is not registered inside this block.
- RESULT and ERR change only on the edge entering FIN.

## Configuration
- SAR_EARLY_EXIT_EN defined:
  - R=3'b010 in SEARCH sets acc[idx] and goes straight to FIN with the lower bits left at 0.
  - Latency drops to (WIDTH-idx)+1 cycles.
- Not defined:
  - An equal result only sets acc[idx]; the search always runs all WIDTH decisions.
  - The remaining lower trials then see A<B and clear their bits.
- RESULT is identical either way for valid comparator behaviour; only latency differs.

## Test plan
- Unknown A=9, START pulse → GUESS sequence 8,12,10,9; RESULT=9, ERR=0, DONE pulse one cycle, BUSY high 4 cycles.
- Unknown A=0 → GUESS 8,4,2,1, all R=001; RESULT=0. Unknown A=15 → GUESS 8,12,14,15; RESULT=15.
- Unknown A=8:
  - With SAR_EARLY_EXIT_EN: BUSY for 1 cycle, DONE on edge 3, RESULT=8.
  - Without it: GUESS 8,12,10,9, RESULT=8, DONE on edge 6.
- Force R=3'b000 on the second decision → ERR=1, RESULT=0, DONE pulse. A following search with A=5 gives RESULT=5 and clears ERR.
- Assert RST_N=0 asynchronously during the 3rd decision cycle → all outputs go to 0 immediately and no DONE follows. A new START with A=6 then gives RESULT=6.
- START held high continuously with A=3 → back-to-back searches each give RESULT=3. START pulses issued during BUSY do not alter the sequence.
